voice_sequencer: RTL and testbench

//   Per-sample scheduler that time-multiplexes one phase adder and one shared sine ROM port across all voices.
//   On each sample tick it walks voices 0..NUM_VOICES-1 and updates each phase register.
//   For each voice it issues a ROM read and sums the gated ROM returns into one mixed sample.

---
 rtl/synth_pkg.sv | 28 ++
 rtl/voice_sequencer_phase_regfile.sv | 41 ++++
 rtl/voice_sequencer.sv | 142 ++++++++++++++
 tb/tb_voice_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants, types and helpers for the voice sequencer slice.
package synth_pkg;

    localparam int NUM_VOICES  = 8;
    localparam int PHASE_W     = 32;
    localparam int ROM_ADDR_W  = 8;
    localparam int SAMPLE_W    = 16;
    localparam int ROM_LATENCY = 2;
    localparam int VIDX_W      = $clog2(NUM_VOICES);
    localparam int MIX_W       = SAMPLE_W + VIDX_W;
    localparam int DRAIN_W     = $clog2(ROM_LATENCY + 1);

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [VIDX_W-1:0]  voice_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

    // Sign-extend a ROM sample to the mix width.
    function automatic logic [MIX_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
        return {{(MIX_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/voice_sequencer_phase_regfile.sv
// Per-voice phase register file with a single read/add/write port.
// Optional feature macro: PHASE_RESET_ON_GATE_EN
//   defined   : an ungated voice's phase is cleared when visited
//   undefined : an ungated voice's phase is held
module phase_regfile
    import synth_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we_in,
    input  voice_idx_t            idx_in,
    input  logic                  gate_in,
    input  phase_t                inc_in,
    output logic [ROM_ADDR_W-1:0] addr_out
);

    phase_t phase_q [NUM_VOICES];
    phase_t phase_d;

    // Next phase for the addressed voice; its top bits form the ROM address.
    always_comb begin
`ifdef PHASE_RESET_ON_GATE_EN
        phase_d = gate_in ? (phase_q[idx_in] + inc_in) : '0;
`else
        phase_d = gate_in ? (phase_q[idx_in] + inc_in) : phase_q[idx_in];
`endif
        addr_out = phase_d[PHASE_W-1 -: ROM_ADDR_W];
    end

    // Phase storage with synchronous clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else if (we_in) begin
            phase_q[idx_in] <= phase_d;
        end
    end

endmodule

// File: rtl/voice_sequencer.sv
// Per-sample voice scheduler: one phase adder and one sine ROM port shared
// across all voices, with gated accumulation into a single mixed sample.
// Optional feature macro (inside phase_regfile): PHASE_RESET_ON_GATE_EN
//
//   state | meaning
//   IDLE  | waiting for a sample tick; voice 0 is issued on the accepting edge
//   ISSUE | issuing voices 1..NUM_VOICES-1, one per cycle
//   DRAIN | waiting for the last ROM reads to return
//   DONE  | mix_out just updated, mix_valid_out high
module voice_sequencer
    import synth_pkg::*;
(
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          sample_tick_in,
    input  logic [NUM_VOICES-1:0]         gate_in,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc_in,
    output logic [ROM_ADDR_W-1:0]         rom_addr_out,
    input  logic [SAMPLE_W-1:0]           rom_data_in,
    output logic [MIX_W-1:0]              mix_out,
    output logic                          mix_valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    seq_state_t              state_q, state_d;
    voice_idx_t              issue_idx_q;
    logic [NUM_VOICES-1:0]   gate_snap_q;
    logic                    addr_gate_q;
    logic [ROM_LATENCY-1:0]  tag_pipe_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;
    logic [MIX_W-1:0]        acc_q, acc_d;

    logic                    rf_we;
    voice_idx_t              rf_idx;
    logic                    rf_gate;
    phase_t                  rf_inc;
    logic [ROM_ADDR_W-1:0]   rf_addr;

    phase_regfile u_phase_regfile (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .we_in    (rf_we),
        .idx_in   (rf_idx),
        .gate_in  (rf_gate),
        .inc_in   (rf_inc),
        .addr_out (rf_addr)
    );

    assign busy_out    = (state_q != IDLE);
    assign overrun_out = sample_tick_in & ~rst_in & (state_q != IDLE);

    // Next-state: the issue index and drain counter terminate each phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick_in) state_d = ISSUE;
            ISSUE:   if (issue_idx_q == voice_idx_t'(NUM_VOICES-1)) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase port steering; voice 0 uses the live gate since the snapshot lands on the same edge.
    always_comb begin
        rf_we   = 1'b0;
        rf_idx  = '0;
        rf_gate = 1'b0;
        if ((state_q == IDLE) && sample_tick_in) begin
            rf_we   = 1'b1;
            rf_gate = gate_in[0];
        end else if (state_q == ISSUE) begin
            rf_we   = 1'b1;
            rf_idx  = issue_idx_q;
            rf_gate = gate_snap_q[issue_idx_q];
        end
        rf_inc = phase_inc_in[int'(rf_idx)*PHASE_W +: PHASE_W];
    end

    // Add returning ROM data only when its tag says the voice was gated.
    always_comb begin
        acc_d = acc_q;
        if (tag_pipe_q[ROM_LATENCY-1]) begin
            acc_d = acc_q + sext_sample(rom_data_in);
        end
    end

    // State, address register, tag pipe, accumulator and mix output.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            issue_idx_q   <= '0;
            gate_snap_q   <= '0;
            addr_gate_q   <= 1'b0;
            tag_pipe_q    <= '0;
            drain_cnt_q   <= '0;
            acc_q         <= '0;
            rom_addr_out  <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
        end else begin
            state_q       <= state_d;
            tag_pipe_q    <= (tag_pipe_q << 1) | ROM_LATENCY'(addr_gate_q);
            acc_q         <= acc_d;
            mix_valid_out <= 1'b0;

            if (rf_we) begin
                rom_addr_out <= rf_addr;
                addr_gate_q  <= rf_gate;
            end else begin
                addr_gate_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sample_tick_in) begin
                        gate_snap_q <= gate_in;
                        issue_idx_q <= voice_idx_t'(1);
                        acc_q       <= '0;
                    end
                end
                ISSUE: begin
                    issue_idx_q <= issue_idx_q + voice_idx_t'(1);
                    if (issue_idx_q == voice_idx_t'(NUM_VOICES-1)) begin
                        drain_cnt_q <= DRAIN_W'(ROM_LATENCY);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q != '0) begin
                        drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
                    end else begin
                        mix_out       <= acc_d;
                        mix_valid_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Self-checking bench for voice_sequencer: a reference phase model predicts
// addresses and mixes; expected mixes are queued at tick time and popped on mix_valid_out.
module tb_voice_sequencer;
    import synth_pkg::*;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic                          sample_tick_in;
    logic [NUM_VOICES-1:0]         gate_in;
    logic [NUM_VOICES*PHASE_W-1:0] phase_inc_in;
    logic [ROM_ADDR_W-1:0]         rom_addr_out;
    logic [SAMPLE_W-1:0]           rom_data_in;
    logic [MIX_W-1:0]              mix_out;
    logic                          mix_valid_out;
    logic                          busy_out;
    logic                          overrun_out;

    typedef struct {
        logic [MIX_W-1:0] mix;
        int               cyc;
    } exp_t;

    exp_t   sb_q[$];
    phase_t mphase [NUM_VOICES];
    phase_t minc   [NUM_VOICES];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    bit     rom_mode = 1'b0;
    logic [SAMPLE_W-1:0] rom_const = '0;
    logic [SAMPLE_W-1:0] rom_pipe [ROM_LATENCY];

    voice_sequencer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_tick_in (sample_tick_in),
        .gate_in        (gate_in),
        .phase_inc_in   (phase_inc_in),
        .rom_addr_out   (rom_addr_out),
        .rom_data_in    (rom_data_in),
        .mix_out        (mix_out),
        .mix_valid_out  (mix_valid_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_inc
        assign phase_inc_in[g*PHASE_W +: PHASE_W] = minc[g];
    end

    function automatic logic [SAMPLE_W-1:0] rom_f(input logic [ROM_ADDR_W-1:0] a);
        return rom_mode ? rom_const : {8'h00, a};
    endfunction

    // ROM model with fixed latency
    always @(posedge clk_in) begin
        rom_pipe[0] <= rom_f(rom_addr_out);
        for (int i = 1; i < ROM_LATENCY; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data_in = rom_pipe[ROM_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: compare every mix_valid pulse against the queued expectation
    always @(negedge clk_in) begin
        exp_t e;
        if (mix_valid_out) begin
            if (sb_q.size() == 0) begin
                check("valid_unexp", 32'(mix_valid_out), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("mix", 32'(mix_out), 32'(e.mix));
                check("mix_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic reset_model();
        for (int v = 0; v < NUM_VOICES; v++) mphase[v] = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        sb_q.delete();
        reset_model();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // One frame: tick, per-cycle address/busy/overrun checks, optional overrun tick or reset.
    task automatic run_frame(input logic [NUM_VOICES-1:0] g, input int ovr_at, input int rst_at);
        logic [ROM_ADDR_W-1:0] ea [NUM_VOICES];
        logic [SAMPLE_W-1:0]   d;
        int mix = 0;
        bit aborted = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (g[v]) mphase[v] = mphase[v] + minc[v];
`ifdef PHASE_RESET_ON_GATE_EN
            else mphase[v] = '0;
`endif
            ea[v] = mphase[v][PHASE_W-1 -: ROM_ADDR_W];
            d = rom_f(ea[v]);
            if (g[v]) mix += int'($signed(d));
        end
        @(negedge clk_in);
        gate_in = g;
        sample_tick_in = 1'b1;
        sb_q.push_back('{mix: MIX_W'(mix), cyc: cyc + NUM_VOICES + ROM_LATENCY + 1});
        #1;
        check("ovr_idle", 32'(overrun_out), 32'(0));
        for (int k = 1; k <= NUM_VOICES + ROM_LATENCY + 2; k++) begin
            @(negedge clk_in);
            sample_tick_in = (k == ovr_at);
            if (k == rst_at) begin
                rst_in = 1'b1;
                aborted = 1'b1;
                sb_q.delete();
                reset_model();
            end else begin
                rst_in = 1'b0;
            end
            #1;
            if (!aborted && k <= NUM_VOICES)
                check("addr", 32'(rom_addr_out), 32'(ea[k-1]));
            if (aborted && k > rst_at)
                check("busy_after_rst", 32'(busy_out), 32'(0));
            else if (!aborted)
                check("busy", 32'(busy_out), 32'(k <= NUM_VOICES + ROM_LATENCY + 1));
            if (ovr_at > 0 && !aborted)
                check("ovr", 32'(overrun_out), 32'(k == ovr_at));
        end
        sample_tick_in = 1'b0;
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        sample_tick_in = 1'b0;
        gate_in = '0;
        for (int v = 0; v < NUM_VOICES; v++) minc[v] = '0;
        reset_model();
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_addr",  32'(rom_addr_out), 32'(0));
        check("rst_mix",   32'(mix_out), 32'(0));
        check("rst_valid", 32'(mix_valid_out), 32'(0));
        check("rst_busy",  32'(busy_out), 32'(0));
        // tick while reset is held is ignored
        sample_tick_in = 1'b1;
        #1;
        check("rst_ovr", 32'(overrun_out), 32'(0));
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        rst_in = 1'b0;
        #1;
        check("rst_tick_busy", 32'(busy_out), 32'(0));

        // single voice, other voices given distinct increments but ungated
        for (int v = 0; v < NUM_VOICES; v++) minc[v] = phase_t'((v + 1) << 24) + phase_t'(v);
        minc[0] = 32'h0100_0000;
        run_frame(8'h01, 0, 0);
        run_frame(8'h01, 0, 0);

        // full chord at max positive, then negative samples
        apply_reset();
        for (int v = 0; v < NUM_VOICES; v++) minc[v] = 32'h0100_0000;
        rom_mode = 1'b1;
        rom_const = 16'h7FFF;
        run_frame(8'hFF, 0, 0);
        rom_const = 16'h8000;
        run_frame(8'h0F, 0, 0);
        rom_mode = 1'b0;

        // overrun tick mid-frame
        run_frame(8'h01, 4, 0);

        // gate drop and re-gate
        apply_reset();
        minc[0] = 32'h0100_0000;
        repeat (3) run_frame(8'h01, 0, 0);
        run_frame(8'h00, 0, 0);
        run_frame(8'h01, 0, 0);

        // phase wrap
        apply_reset();
        minc[0] = 32'h8000_0000;
        run_frame(8'h01, 0, 0);
        run_frame(8'h01, 0, 0);

        // reset mid-frame
        apply_reset();
        minc[0] = 32'h0100_0000;
        run_frame(8'h01, 0, 5);
        run_frame(8'h01, 0, 0);

        // random gates and increments
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NUM_VOICES; v++) minc[v] = phase_t'($urandom);
            run_frame(NUM_VOICES'($urandom_range(0, 255)), 0, 0);
        end

        repeat (5) @(negedge clk_in);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
